// File: rtl/tdc_hit_sequencer.sv
// TDC input-stage sequencer: arm, timestamp, tap latch strobe, chain clear, dead time.
// Optional ARMED watchdog is built when TDC_ARM_TIMEOUT_EN is defined.
module tdc_hit_sequencer #(
    parameter int COARSE_W       = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int CLR_CYCLES     = 2,
    parameter int DEAD_CYCLES    = 4,
    parameter int DROP_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                iRst,
    input  logic                iEnable,
    input  logic                iHitFlag,
    input  logic                iReady,
    output logic                oArm,
    output logic                oLatch,
    output logic                oChainClr,
    output logic                oValid,
    output logic [COARSE_W-1:0] oCoarse,
    output logic                oDrop,
    output logic [DROP_W-1:0]   oDropCnt,
    output logic                oTimeout
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LATCH,
        CLEAR,
        DEAD
    } seqState_t;

    localparam int PH_MAX = (CLR_CYCLES > DEAD_CYCLES) ? CLR_CYCLES : DEAD_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    generate
        if (SYNC_STAGES < 2) begin : gBadSync
            $error("SYNC_STAGES must be at least 2");
        end
        if (CLR_CYCLES < 1) begin : gBadClr
            $error("CLR_CYCLES must be at least 1");
        end
        if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    seqState_t state;
    seqState_t stateNext;

    logic [COARSE_W-1:0]    coarseCnt;
    logic [COARSE_W-1:0]    capCnt;
    logic [SYNC_STAGES-1:0] syncQ;
    logic                   syncPrev;
    logic                   hitDet;
    logic [PH_W-1:0]        phaseCnt;
    logic                   slotFree;

    always_ff @(posedge clk or negedge iRst) begin
        if (!iRst) begin
            coarseCnt <= '0;
        end else if (iEnable) begin
            coarseCnt <= coarseCnt + COARSE_W'(1);
        end
    end

    // Edge detector tracks the flag in every state so a held flag never re-triggers.
    always_ff @(posedge clk or negedge iRst) begin
        if (!iRst) begin
            syncQ    <= '0;
            syncPrev <= 1'b0;
            hitDet   <= 1'b0;
        end else begin
            syncQ    <= {syncQ[SYNC_STAGES-2:0], iHitFlag};
            syncPrev <= syncQ[SYNC_STAGES-1];
            hitDet   <= syncQ[SYNC_STAGES-1] & ~syncPrev;
        end
    end

`ifdef TDC_ARM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdCnt;
    logic            wdExpired;
    logic            timeoutFire;
    logic            timeoutQ;

    assign wdExpired = (state == ARMED) &&
                       (wdCnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge iRst) begin
        if (!iRst) begin
            wdCnt    <= '0;
            timeoutQ <= 1'b0;
        end else begin
            wdCnt    <= (state == ARMED) ? wdCnt + WD_W'(1) : '0;
            timeoutQ <= timeoutFire;
        end
    end

    assign oTimeout = timeoutQ;
`else
    assign oTimeout = 1'b0;
`endif

    always_comb begin
        stateNext = state;
`ifdef TDC_ARM_TIMEOUT_EN
        timeoutFire = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (iEnable) begin
                    stateNext = ARMED;
                end
            end
            ARMED: begin
                if (hitDet) begin
                    stateNext = LATCH;
                end else if (!iEnable) begin
                    stateNext = IDLE;
`ifdef TDC_ARM_TIMEOUT_EN
                end else if (wdExpired) begin
                    stateNext   = CLEAR;
                    timeoutFire = 1'b1;
`endif
                end
            end
            LATCH: begin
                stateNext = CLEAR;
            end
            CLEAR: begin
                if (phaseCnt == PH_W'(CLR_CYCLES - 1)) begin
                    if (DEAD_CYCLES == 0) begin
                        stateNext = iEnable ? ARMED : IDLE;
                    end else begin
                        stateNext = DEAD;
                    end
                end
            end
            DEAD: begin
                if (phaseCnt == PH_W'(DEAD_CYCLES - 1)) begin
                    stateNext = iEnable ? ARMED : IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge iRst) begin
        if (!iRst) begin
            state    <= IDLE;
            phaseCnt <= '0;
            capCnt   <= '0;
        end else begin
            state <= stateNext;
            if ((stateNext != state) || !((state == CLEAR) || (state == DEAD))) begin
                phaseCnt <= '0;
            end else begin
                phaseCnt <= phaseCnt + PH_W'(1);
            end
            if ((state == ARMED) && hitDet) begin
                capCnt <= coarseCnt;
            end
        end
    end

    // The slot is reusable in the same cycle the held event is taken.
    assign slotFree = !oValid || iReady;

    always_ff @(posedge clk or negedge iRst) begin
        if (!iRst) begin
            oValid   <= 1'b0;
            oCoarse  <= '0;
            oDrop    <= 1'b0;
            oDropCnt <= '0;
        end else begin
            oDrop <= 1'b0;
            if ((state == LATCH) && slotFree) begin
                oValid  <= 1'b1;
                oCoarse <= capCnt;
            end else if (oValid && iReady) begin
                oValid <= 1'b0;
            end
            if ((state == LATCH) && !slotFree) begin
                oDrop <= 1'b1;
                if (oDropCnt != '1) begin
                    oDropCnt <= oDropCnt + DROP_W'(1);
                end
            end
        end
    end

    assign oArm      = (state == ARMED);
    assign oLatch    = (state == LATCH);
    assign oChainClr = (state == CLEAR);

endmodule

// File: tb/tb_tdc_hit_sequencer.sv
// Scoreboard bench for tdc_hit_sequencer: randomized hits and readout back-pressure.
// Expected events come from a latency/slot model derived from the block's timing rules.
module tb_tdc_hit_sequencer;

    localparam int CW   = 12;
    localparam int N    = 8000;
    localparam int CLR  = 2;
    localparam int DEAD = 4;

    logic          clk = 1'b0;
    logic          iRst;
    logic          iEnable;
    logic          iHitFlag;
    logic          iReady;
    logic          oArm;
    logic          oLatch;
    logic          oChainClr;
    logic          oValid;
    logic [CW-1:0] oCoarse;
    logic          oDrop;
    logic [7:0]    oDropCnt;
    logic          oTimeout;

    tdc_hit_sequencer #(
        .COARSE_W (CW)
    ) dut (
        .clk       (clk),
        .iRst      (iRst),
        .iEnable   (iEnable),
        .iHitFlag  (iHitFlag),
        .iReady    (iReady),
        .oArm      (oArm),
        .oLatch    (oLatch),
        .oChainClr (oChainClr),
        .oValid    (oValid),
        .oCoarse   (oCoarse),
        .oDrop     (oDrop),
        .oDropCnt  (oDropCnt),
        .oTimeout  (oTimeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit isDrop;
        int coarse;
        int dcnt;
    } ev_t;

    ev_t expQ[$];
    bit  hitW[N];
    bit  rdyW[N];
    bit  expArm[N+32];
    bit  expLat[N+32];
    bit  expClr[N+32];

    int  vecs = 0;
    int  fails = 0;
    int  cyc = 0;
    int  totalDrops = 0;
    bit  monOn = 1'b0;
    bit  prevValid = 1'b0;
    bit  prevReady = 1'b0;
    int  prevCoarse = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Builds hit/ready waveforms, then predicts every event from latency rules.
    task automatic buildStimulus();
        int s;
        int w;
        int g;
        int armedFrom;
        int lastVis;
        int L;
        bit free;
        ev_t e;
        s = 20;
        while (s < N - 60) begin
            if (s < 1000) begin
                w = $urandom_range(1, 3);
                g = $urandom_range(6, 25);
            end else if (s < 5000) begin
                w = 1;
                g = $urandom_range(7, 11);
            end else begin
                w = $urandom_range(1, 3);
                g = $urandom_range(1, 14);
            end
            for (int i = 0; i < w; i++) hitW[s+i] = 1'b1;
            s += w + g;
        end
        for (int t = 0; t < N; t++) begin
            if (t < 1000 || t >= N - 60) rdyW[t] = 1'b1;
            else if (t < 5000) rdyW[t] = 1'b0;
            else rdyW[t] = 1'($urandom_range(0, 1));
        end
        armedFrom = 1;
        lastVis = -1;
        for (int t = 1; t < N; t++) begin
            if (hitW[t] && !hitW[t-1] && (t + 3 >= armedFrom)) begin
                L = t + 4;
                for (int a = armedFrom; a <= t + 3; a++) expArm[a] = 1'b1;
                expLat[L] = 1'b1;
                for (int c = 1; c <= CLR; c++) expClr[L+c] = 1'b1;
                armedFrom = L + 1 + CLR + DEAD;
                if (lastVis < 0) begin
                    free = 1'b1;
                end else begin
                    free = 1'b0;
                    for (int u = lastVis; u <= L; u++) if (rdyW[u]) free = 1'b1;
                end
                e.coarse = (t + 3) % (1 << CW);
                if (free) begin
                    e.isDrop = 1'b0;
                    e.dcnt = 0;
                    lastVis = L + 1;
                end else begin
                    totalDrops++;
                    e.isDrop = 1'b1;
                    e.dcnt = (totalDrops > 255) ? 255 : totalDrops;
                end
                expQ.push_back(e);
            end
        end
        for (int a = armedFrom; a < N; a++) expArm[a] = 1'b1;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (monOn) begin
            chk("ctrl_arm_latch_clr_to",
                int'({oArm, oLatch, oChainClr, oTimeout}),
                int'({expArm[cyc], expLat[cyc], expClr[cyc], 1'b0}));
            if (prevValid && !prevReady) begin
                chk("hold_valid", int'(oValid), 1);
                chk("hold_coarse", int'(oCoarse), prevCoarse);
            end
            if (oValid && (!prevValid || prevReady)) begin
                chk("load_expected", int'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    chk("load_kind", int'(e.isDrop), 0);
                    chk("load_coarse", int'(oCoarse), e.coarse);
                end
            end
            if (oDrop) begin
                chk("drop_expected", int'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    chk("drop_kind", int'(e.isDrop), 1);
                    chk("drop_count", int'(oDropCnt), e.dcnt);
                end
            end
            prevValid  = oValid;
            prevReady  = iReady;
            prevCoarse = int'(oCoarse);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: time limit reached, vectors %0d", vecs);
        $fatal(1, "time limit");
    end

    initial begin
        bit seen;
        iRst = 1'b0;
        iEnable = 1'b1;
        iHitFlag = 1'b0;
        iReady = 1'b0;
        buildStimulus();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            int'({oArm, oLatch, oChainClr, oValid, oDrop, oTimeout}), 0);
        chk("reset_coarse", int'(oCoarse), 0);
        chk("reset_dropcnt", int'(oDropCnt), 0);
        iRst = 1'b1;
        monOn = 1'b1;
        for (int t = 0; t < N; t++) begin
            cyc = t;
            iHitFlag = hitW[t];
            iReady = rdyW[t];
            @(posedge clk);
            #1;
        end
        monOn = 1'b0;
        chk("pending_events", expQ.size(), 0);
        chk("final_dropcnt", int'(oDropCnt), (totalDrops > 255) ? 255 : totalDrops);

        // Reset in the middle of a chain clear.
        iReady = 1'b1;
        iHitFlag = 1'b1;
        @(posedge clk);
        #1;
        iHitFlag = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (oChainClr) seen = 1'b1;
        end
        chk("clear_reached", int'(seen), 1);
        #2;
        iRst = 1'b0;
        #1;
        chk("midreset_outputs",
            int'({oArm, oLatch, oChainClr, oValid, oDrop, oTimeout}), 0);
        chk("midreset_coarse", int'(oCoarse), 0);
        chk("midreset_dropcnt", int'(oDropCnt), 0);
        @(posedge clk);
        #1;
        chk("held_reset_ctrl", int'({oArm, oChainClr}), 0);
        iRst = 1'b1;

        // Post-reset timeline with an enable gap that freezes the counter.
        for (int c = 0; c < 46; c++) begin
            cyc = c;
            iEnable = !(c >= 20 && c < 30);
            iHitFlag = (c == 5 || c == 35);
            iReady = 1'b1;
            @(negedge clk);
            if (c == 0)  chk("post_idle_arm", int'(oArm), 0);
            if (c == 1)  chk("post_arm", int'(oArm), 1);
            if (c == 8)  chk("pre_latch", int'(oLatch), 0);
            if (c == 9)  chk("hit_latch", int'(oLatch), 1);
            if (c == 10) chk("hit_valid", int'(oValid), 1);
            if (c == 10) chk("hit_coarse", int'(oCoarse), 8);
            if (c == 10 || c == 11) chk("clr_on", int'(oChainClr), 1);
            if (c == 12) chk("clr_off", int'(oChainClr), 0);
            if (c == 15) chk("dead_arm", int'(oArm), 0);
            if (c == 16) chk("rearm", int'(oArm), 1);
            if (c == 21) chk("disable_idle", int'(oArm), 0);
            if (c == 31) chk("enable_arm", int'(oArm), 1);
            if (c == 39) chk("hit2_latch", int'(oLatch), 1);
            if (c == 40) chk("hit2_valid", int'(oValid), 1);
            if (c == 40) chk("hit2_coarse", int'(oCoarse), 28);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
